beehive_frame_arbiter: RTL and testbench
========================================

Name: beehive_frame_arbiter

Overview:
- Frame-atomic round-robin arbiter that shares one MAC-engine TX frame interface among NUM_SRC producer engines.
- Upstream side: each source presents a val/rdy frame stream (256-bit beats, startframe/endframe, frame_size, padbytes).
- Downstream side: one stream toward the MAC/loopback path.
- Once granted, a source keeps the output until its endframe beat completes. The block also checks beat count against frame_size.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..8)
- DATA_W, 256, beat width in bits
- FRAME_SIZE_W, 11, frame_size width (bytes, max 1500)
- PADBYTES_W, 5, padbytes width (log2 of DATA_W/8)
- IDX_W, $clog2(NUM_SRC), source index width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- src_val  in  NUM_SRC  per-source beat valid
- src_data  in  NUM_SRC*DATA_W  per-source beat data, source i at [i*DATA_W +: DATA_W]
- src_startframe  in  NUM_SRC  first beat of frame
- src_endframe  in  NUM_SRC  last beat of frame
- src_frame_size  in  NUM_SRC*FRAME_SIZE_W  frame byte count, sampled on start beat
- src_padbytes  in  NUM_SRC*PADBYTES_W  invalid bytes in last beat
- src_rdy  out  NUM_SRC  per-source ready
- dst_val  out  1  output beat valid
- dst_data  out  DATA_W  output beat data
- dst_startframe  out  1  first beat
- dst_endframe  out  1  last beat
- dst_frame_size  out  FRAME_SIZE_W  frame byte count
- dst_padbytes  out  PADBYTES_W  pad bytes
- dst_rdy  in  1  downstream ready
- grant_idx  out  IDX_W  currently granted source
- busy  out  1  high while in LOCKED
- err_len  out  1  one-cycle pulse on a beat-count mismatch

Behaviour:
- Reset: asynchronous, active-high.
  - state=IDLE, rr_ptr=0, grant_idx=0, beat_cnt=0, exp_beats=0, err_len=0.
  - All combinational outputs are then 0, because src_rdy=0 and dst_val=0 in IDLE.
- States:
  - IDLE: no grant. src_rdy=0, dst_val=0.
  - LOCKED: the granted source g is muxed to dst with zero latency.
    - dst_val=src_val[g]; data, start, end, size and padbytes are taken from source g.
    - src_rdy[g]=dst_rdy; all other src_rdy bits are 0.
- IDLE to LOCKED:
  - Requesters are sources with src_val[i] && src_startframe[i].
  - The winner is the first requester at or after rr_ptr, searching cyclically.
  - The winner is registered into grant_idx. The first beat transfers no earlier than the next cycle, so arbitration adds 1 cycle of latency.
- Stray beats: a source with src_val=1 but startframe=0 while in IDLE is not a requester. It stays stalled (rdy=0) and raises no error.
- Handshake rules:
  - A beat transfers when dst_val && dst_rdy.
  - Sources must hold their beat stable until rdy.
  - No combinational path from dst_rdy to dst_val.
- Beat counting:
  - On the start beat transfer: exp_beats = ceil(frame_size/32), computed as (frame_size+31)>>5 at FRAME_SIZE_W+1 width; beat_cnt=1.
  - On each later transfer: beat_cnt+1.
  - frame_size=0 gives exp_beats=0, which always flags err_len.
- LOCKED to IDLE:
  - On the endframe beat transfer: rr_ptr = (g+1) mod NUM_SRC.
  - In the same cycle, if the counted beats (including the end beat) != exp_beats, err_len pulses 1 for the next cycle.
- Single-beat frame (start and end on the same beat) is legal. It compares 1 against exp_beats.
- A start beat arriving mid-frame on the granted source is passed through but resets beat_cnt/exp_beats; the count restarts at that beat.
- Back-to-back grants: none in the same cycle as endframe. The next arbitration happens in the cycle after returning to IDLE, so the minimum gap between frames is 1 cycle.
- Reset mid-frame: returns to IDLE immediately. The partial frame is abandoned; the downstream must tolerate a truncated frame. rr_ptr returns to 0.
- Counter widths: beat_cnt saturates at 2^(FRAME_SIZE_W-4)-1. Overflow forces a mismatch.

Decomposition:
- Shared package beehive_arb_pkg holds:
  - MAC_INTERFACE_W=256, MTU_SIZE_W=11, MAC_PADBYTES_W=5, MAC_INTERFACE_BYTES=32
  - the arb_state_e enum (IDLE, LOCKED)
  - a function beats_from_size()
- One natural sub-module: rr_arbiter. It takes a request vector and a pointer and returns a one-hot grant plus encoded index, purely combinationally. The FSM, mux and length check stay in the top.

Test Plan:
- NUM_SRC=4, only src2 sends a frame of 64 bytes (2 beats), dst_rdy=1 -> busy rises the next cycle, 2 beats out with grant_idx=2, err_len=0, rr_ptr=3.
- All 4 sources request simultaneously with 1-beat frames (frame_size=20) -> grant order 0,1,2,3; one idle cycle between frames; no beat interleaving.
- src0 sends 3 beats with frame_size=100 (exp 4) -> err_len pulses once, exactly one cycle after the end beat.
- Downstream applies random dst_rdy backpressure during a 1500-byte frame (47 beats) -> data is intact and in order; non-granted src_rdy stays 0 throughout; err_len=0.
- rst asserted after beat 2 of 5 -> all outputs go to 0 asynchronously; after release, src1 (not src0's remainder) can win if requesting with startframe.
- src3 holds val=1 with startframe=0 while in IDLE -> never granted, src_rdy[3]=0, while other sources are still served.

Source files
------------

// File: rtl/beehive_arb_pkg.sv
// Shared constants, state encoding and sizing helper for the Beehive TX frame arbiter.
package beehive_arb_pkg;

    localparam int MAC_INTERFACE_W     = 256;
    localparam int MTU_SIZE_W          = 11;
    localparam int MAC_PADBYTES_W      = 5;
    localparam int MAC_INTERFACE_BYTES = 32;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Beats needed to carry `size` bytes: ceil(size / bytes-per-beat).
    // Callers truncate the result to their own counter width.
    function automatic logic [31:0] beats_from_size(input logic [31:0] size);
        return (size + 32'(MAC_INTERFACE_BYTES - 1)) >> $clog2(MAC_INTERFACE_BYTES);
    endfunction

endpackage

// File: rtl/beehive_frame_arbiter_rr.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);

    logic [31:0]      cand;
    logic [IDX_W-1:0] cand_i;
    logic             found;

    // Walk the sources cyclically from ptr and keep the first requester seen.
    always_comb begin
        gnt    = '0;
        idx    = '0;
        found  = 1'b0;
        cand   = '0;
        cand_i = '0;
        for (int k = 0; k < N; k++) begin
            cand = 32'(ptr) + 32'(k);
            if (cand >= 32'(N)) cand = cand - 32'(N);
            cand_i = IDX_W'(cand);
            if (!found && req[cand_i]) begin
                found       = 1'b1;
                gnt[cand_i] = 1'b1;
                idx         = cand_i;
            end
        end
    end

endmodule

// File: rtl/beehive_frame_arbiter.sv
// Frame-atomic round-robin arbiter sharing one MAC TX stream among NUM_SRC
// producers; the granted source is muxed through with zero latency and its
// beat count is checked against frame_size when the frame ends.
module beehive_frame_arbiter
    import beehive_arb_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int DATA_W       = MAC_INTERFACE_W,
    parameter int FRAME_SIZE_W = MTU_SIZE_W,
    parameter int PADBYTES_W   = MAC_PADBYTES_W,
    parameter int IDX_W        = $clog2(NUM_SRC)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_SRC-1:0]              src_val,
    input  logic [NUM_SRC*DATA_W-1:0]       src_data,
    input  logic [NUM_SRC-1:0]              src_startframe,
    input  logic [NUM_SRC-1:0]              src_endframe,
    input  logic [NUM_SRC*FRAME_SIZE_W-1:0] src_frame_size,
    input  logic [NUM_SRC*PADBYTES_W-1:0]   src_padbytes,
    output logic [NUM_SRC-1:0]              src_rdy,
    output logic                            dst_val,
    output logic [DATA_W-1:0]               dst_data,
    output logic                            dst_startframe,
    output logic                            dst_endframe,
    output logic [FRAME_SIZE_W-1:0]         dst_frame_size,
    output logic [PADBYTES_W-1:0]           dst_padbytes,
    input  logic                            dst_rdy,
    output logic [IDX_W-1:0]                grant_idx,
    output logic                            busy,
    output logic                            err_len
);

    // Beat counter saturates well above the largest legal expected count, so
    // a runaway frame always reads as a mismatch.
    localparam int              CNT_W   = FRAME_SIZE_W - 4;
    localparam int              EXP_W   = FRAME_SIZE_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    arb_state_e         state, state_nxt;
    logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0]   beat_cnt, cnt_now;
    logic [EXP_W-1:0]   exp_beats, exp_now;
    logic [NUM_SRC-1:0] req, arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic               xfer, end_xfer;
    logic               cnt_ovf, mismatch;

    // Only a valid start beat may claim the output; stray mid-frame beats wait.
    assign req     = src_val & src_startframe;
    assign arb_any = |arb_gnt;

    rr_arbiter #(.N(NUM_SRC), .IDX_W(IDX_W)) u_rr (
        .req (req),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    // Zero-latency mux of the granted source; everything idles low otherwise.
    always_comb begin
        src_rdy        = '0;
        dst_val        = 1'b0;
        dst_data       = '0;
        dst_startframe = 1'b0;
        dst_endframe   = 1'b0;
        dst_frame_size = '0;
        dst_padbytes   = '0;
        if (state == LOCKED) begin
            dst_val            = src_val[grant_idx];
            dst_data           = src_data[32'(grant_idx)*DATA_W +: DATA_W];
            dst_startframe     = src_startframe[grant_idx];
            dst_endframe       = src_endframe[grant_idx];
            dst_frame_size     = src_frame_size[32'(grant_idx)*FRAME_SIZE_W +: FRAME_SIZE_W];
            dst_padbytes       = src_padbytes[32'(grant_idx)*PADBYTES_W +: PADBYTES_W];
            src_rdy[grant_idx] = dst_rdy;
        end
    end

    assign xfer     = dst_val && dst_rdy;
    assign end_xfer = xfer && dst_endframe;
    assign busy     = (state == LOCKED);

    // Count as it would stand after this beat; a start beat restarts the count.
    always_comb begin
        cnt_ovf = 1'b0;
        if (dst_startframe) begin
            cnt_now = CNT_W'(1);
            exp_now = EXP_W'(beats_from_size(32'(dst_frame_size)));
        end else begin
            cnt_ovf = (beat_cnt == CNT_MAX);
            cnt_now = cnt_ovf ? beat_cnt : beat_cnt + CNT_W'(1);
            exp_now = exp_beats;
        end
        mismatch = cnt_ovf || (EXP_W'(cnt_now) != exp_now);
    end

    // Next state: grant on any start request, release after the end beat moves.
    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = (grant_idx == IDX_W'(NUM_SRC - 1)) ? '0 : grant_idx + IDX_W'(1);
        case (state)
            IDLE:    if (arb_any)  state_nxt = LOCKED;
            LOCKED:  if (end_xfer) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Grant, fairness pointer, length bookkeeping and the one-cycle error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            grant_idx <= '0;
            beat_cnt  <= '0;
            exp_beats <= '0;
            err_len   <= 1'b0;
        end else begin
            err_len <= 1'b0;
            if (state == IDLE && arb_any) grant_idx <= arb_idx;
            if (xfer) begin
                beat_cnt  <= cnt_now;
                exp_beats <= exp_now;
            end
            if (end_xfer) begin
                rr_ptr  <= rr_ptr_nxt;
                err_len <= mismatch;
            end
        end
    end

endmodule

// File: tb/tb_beehive_frame_arbiter.sv
// Self-checking bench: source queues feed the DUT, a scoreboard holds the
// expected output beats in predicted grant order, a monitor compares them.
module tb_beehive_frame_arbiter;
    import beehive_arb_pkg::*;

    localparam int NUM_SRC = 4;
    localparam int DATA_W  = 256;
    localparam int FSW     = 11;
    localparam int PW      = 5;
    localparam int IDX_W   = 2;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NUM_SRC-1:0]         src_val, src_startframe, src_endframe, src_rdy;
    logic [NUM_SRC*DATA_W-1:0]  src_data;
    logic [NUM_SRC*FSW-1:0]     src_frame_size;
    logic [NUM_SRC*PW-1:0]      src_padbytes;
    logic                       dst_val, dst_startframe, dst_endframe, dst_rdy;
    logic [DATA_W-1:0]          dst_data;
    logic [FSW-1:0]             dst_frame_size;
    logic [PW-1:0]              dst_padbytes;
    logic [IDX_W-1:0]           grant_idx;
    logic                       busy, err_len;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              start;
        logic              fin;
        logic [FSW-1:0]    size;
        logic [PW-1:0]     pad;
    } beat_t;

    typedef struct {
        int    src;
        beat_t b;
        logic  err;
    } exp_t;

    typedef struct {
        int   src;
        int   size;
        int   nbeats;
        logic err;
        logic bp;
    } vec_t;

    beat_t src_q [NUM_SRC][$];
    exp_t  sb_q[$];
    int    checks = 0;
    int    errors = 0;
    logic  bp_mode = 1'b0;

    beehive_frame_arbiter #(
        .NUM_SRC(NUM_SRC), .DATA_W(DATA_W), .FRAME_SIZE_W(FSW),
        .PADBYTES_W(PW), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst(rst),
        .src_val(src_val), .src_data(src_data),
        .src_startframe(src_startframe), .src_endframe(src_endframe),
        .src_frame_size(src_frame_size), .src_padbytes(src_padbytes),
        .src_rdy(src_rdy),
        .dst_val(dst_val), .dst_data(dst_data),
        .dst_startframe(dst_startframe), .dst_endframe(dst_endframe),
        .dst_frame_size(dst_frame_size), .dst_padbytes(dst_padbytes),
        .dst_rdy(dst_rdy),
        .grant_idx(grant_idx), .busy(busy), .err_len(err_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [299:0] act, input logic [299:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Queue a frame on source s; the first nsb beats are expected downstream.
    task automatic push_frame(input int s, input int size, input int nbeats,
                              input logic err, input int nsb);
        beat_t b;
        exp_t  e;
        for (int i = 0; i < nbeats; i++) begin
            b.data  = {$urandom(), $urandom(), $urandom(), $urandom(),
                       $urandom(), $urandom(), $urandom(), $urandom()};
            b.start = (i == 0);
            b.fin   = (i == nbeats - 1);
            b.size  = FSW'(size);
            b.pad   = PW'((32 - size % 32) % 32);
            src_q[s].push_back(b);
            if (i < nsb) begin
                e.src = s;
                e.b   = b;
                e.err = b.fin ? err : 1'b0;
                sb_q.push_back(e);
            end
        end
    endtask

    // Sources present their queue head; a beat retires after the edge it moved on.
    task automatic driver();
        logic [NUM_SRC-1:0] acc;
        forever begin
            @(negedge clk);
            acc = src_val & src_rdy;
            @(posedge clk);
            #1;
            for (int s = 0; s < NUM_SRC; s++) begin
                if (acc[s] && src_q[s].size() > 0) void'(src_q[s].pop_front());
                if (src_q[s].size() > 0) begin
                    src_val[s]                      = 1'b1;
                    src_data[s*DATA_W +: DATA_W]    = src_q[s][0].data;
                    src_startframe[s]               = src_q[s][0].start;
                    src_endframe[s]                 = src_q[s][0].fin;
                    src_frame_size[s*FSW +: FSW]    = src_q[s][0].size;
                    src_padbytes[s*PW +: PW]        = src_q[s][0].pad;
                end else begin
                    src_val[s]        = 1'b0;
                    src_startframe[s] = 1'b0;
                    src_endframe[s]   = 1'b0;
                end
            end
            dst_rdy = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    // Compares every downstream beat, the error pulse timing and rdy isolation.
    task automatic monitor();
        logic                err_exp;
        logic [NUM_SRC-1:0]  mask;
        exp_t                e;
        err_exp = 1'b0;
        forever begin
            @(negedge clk);
            check("err_len", 300'(err_len), 300'(err_exp));
            err_exp = 1'b0;
            if (busy && sb_q.size() > 0) begin
                mask = '1;
                mask[sb_q[0].src] = 1'b0;
                check("other_rdy", 300'(src_rdy & mask), 300'(0));
            end
            if (dst_val && dst_rdy) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beat: unexpected beat from grant %0d", grant_idx);
                end else begin
                    e = sb_q.pop_front();
                    check("beat",
                          300'({grant_idx, dst_startframe, dst_endframe, dst_frame_size, dst_padbytes, dst_data}),
                          300'({IDX_W'(e.src), e.b.start, e.b.fin, e.b.size, e.b.pad, e.b.data}));
                    if (e.b.fin) err_exp = e.err;
                end
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (sb_q.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: %0d beats outstanding after %0d cycles", sb_q.size(), n);
            sb_q.delete();
            for (int s = 0; s < NUM_SRC; s++) src_q[s].delete();
        end
        repeat (3) @(negedge clk);
        check("idle_busy", 300'(busy), 300'(0));
        check("idle_rdy", 300'(src_rdy), 300'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [7];
        beat_t stray;
        vecs[0] = '{2,   64,  2, 1'b0, 1'b0};
        vecs[1] = '{0,  100,  3, 1'b1, 1'b0};
        vecs[2] = '{1,    0,  1, 1'b1, 1'b0};
        vecs[3] = '{3,   32,  1, 1'b0, 1'b0};
        vecs[4] = '{1,   33,  1, 1'b1, 1'b0};
        vecs[5] = '{0, 1500, 47, 1'b0, 1'b1};
        vecs[6] = '{2,   96,  4, 1'b1, 1'b0};

        rst = 1'b1;
        src_val = '0; src_startframe = '0; src_endframe = '0;
        src_data = '0; src_frame_size = '0; src_padbytes = '0;
        dst_rdy = 1'b0;
        #2;
        check("rst_dst_val", 300'(dst_val), 300'(0));
        check("rst_src_rdy", 300'(src_rdy), 300'(0));
        check("rst_busy", 300'(busy), 300'(0));
        check("rst_grant", 300'(grant_idx), 300'(0));
        check("rst_err", 300'(err_len), 300'(0));
        fork
            driver();
            monitor();
        join_none
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // All four request 1-beat frames together: order 0..3, one idle cycle between.
        @(negedge clk);
        for (int s = 0; s < NUM_SRC; s++) push_frame(s, 20, 1, 1'b0, 1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("gap_pattern", 300'(dst_val), 300'(i % 2));
        end
        wait_idle(50);

        // Lone src2 frame: busy rises the cycle after the request is seen.
        @(negedge clk);
        push_frame(2, 64, 2, 1'b0, 2);
        @(negedge clk);
        check("arb_busy0", 300'(busy), 300'(0));
        check("arb_val0", 300'(dst_val), 300'(0));
        @(negedge clk);
        check("arb_busy1", 300'(busy), 300'(1));
        check("arb_grant", 300'(grant_idx), 300'(2));
        wait_idle(50);

        // Single-source frames covering length-check outcomes and backpressure.
        for (int v = 0; v < 7; v++) begin
            bp_mode = vecs[v].bp;
            @(negedge clk);
            push_frame(vecs[v].src, vecs[v].size, vecs[v].nbeats, vecs[v].err, vecs[v].nbeats);
            wait_idle(400);
            bp_mode = 1'b0;
        end

        // Reset after beat 2 of 5: outputs drop at once, src1 wins afterwards.
        @(negedge clk);
        push_frame(0, 160, 5, 1'b0, 2);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_val", 300'(dst_val), 300'(0));
        check("mid_rst_rdy", 300'(src_rdy), 300'(0));
        check("mid_rst_busy", 300'(busy), 300'(0));
        check("mid_rst_grant", 300'(grant_idx), 300'(0));
        push_frame(1, 32, 1, 1'b0, 1);
        @(negedge clk);
        rst = 1'b0;
        wait_idle(50);
        check("remainder_held", 300'(src_q[0].size()), 300'(3));
        src_q[0].delete();

        // src3 presents a stray non-start beat while others are served.
        @(negedge clk);
        stray = '{data: '1, start: 1'b0, fin: 1'b0, size: FSW'(64), pad: '0};
        src_q[3].push_back(stray);
        push_frame(1, 64, 2, 1'b0, 2);
        wait_idle(50);
        push_frame(2, 96, 3, 1'b0, 3);
        wait_idle(50);
        check("stray_held", 300'(src_q[3].size()), 300'(1));
        src_q[3].delete();
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
